// File: rtl/bsh_req_buf.sv
// bsh_req_buf: request FIFO and registered result slot around the bsh_32 rotator.
//
// Rotate requests arrive on a valid/ready interface and are queued in a
// DEPTH-entry FIFO. The FIFO head is shown to the external combinational
// rotator (sh_data/sh_dir/sh_amt -> sh_result). When the output slot is free
// or being drained, the rotated word and the head's tag are captured into the
// slot, which is presented on out_valid/out_ready.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            synchronous clear of FIFO and output slot
//   in_valid/ready   request handshake; in_ready = (count < DEPTH)
//   in_data/dir/sh   word, direction (1 = right) and amount of the rotate
//   in_tag           user tag, returned with the result
//   sh_data/dir/amt  FIFO head, to the rotator
//   sh_result        rotator output
//   out_valid/ready  result handshake
//   out_data/tag     rotated word and its tag
//   level            FIFO occupancy (registered)
module bsh_req_buf #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_dir,
    input  logic [4:0]       in_sh,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      sh_data,
    output logic             sh_dir,
    output logic [4:0]       sh_amt,
    input  logic [31:0]      sh_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [AW:0]      level
);

    typedef struct packed {
        logic [31:0]      data;
        logic             dir;
        logic [4:0]       sh;
        logic [TAG_W-1:0] tag;
    } req_t;

    req_t          mem [DEPTH];
    req_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    // Full blocks input even if a pop happens this cycle: no full bypass.
    assign in_ready = (count < (AW+1)'(DEPTH));
    // flush wins over both handshakes; the flush-cycle request is dropped.
    assign push     = in_valid & in_ready & ~flush;
    assign pop      = (count != '0) & (~out_valid | out_ready) & ~flush;

    assign head    = mem[rd_ptr];
    assign sh_data = head.data;
    assign sh_dir  = head.dir;
    assign sh_amt  = head.sh;
    assign level   = count;

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{data: in_data, dir: in_dir, sh: in_sh, tag: in_tag};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Result slot: capture on pop, otherwise release on consumer accept.
    // Data and tag hold after release so they stay stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= sh_result;
            out_tag   <= head.tag;
        end else if (out_ready && out_valid) begin
            out_valid <= 1'b0;
        end
    end

endmodule
